rca_wb_serializer: RTL and testbench

Downstream of the RCA unit's writeback interface. Accepts one completed RCA use instruction per cycle:
- instruction ID
- up to NUM_WRITE_PORTS result words
- destination register addresses

Buffers these in a small in-order FIFO and serializes them into single-port register-file write requests with a valid/ack handshake. Emits a one-cycle retire pulse carrying the instruction ID once every write of that instruction has been accepted.

---
 rtl/rca_wb_serializer_pkg.sv | 14 +
 rtl/rca_wb_entry_fifo.sv | 37 +++
 rtl/rca_wb_serializer.sv | 98 +++++++++
 tb/tb_rca_wb_serializer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_wb_serializer_pkg.sv
// rca_wb_serializer_pkg: shared RCA writeback types, constants and head-state encoding
package rca_wb_serializer_pkg;
   localparam int NUM_WRITE_PORTS = 4;
   localparam int XLEN = 32;
   localparam int ID_W = 4;
   typedef logic [ID_W-1:0] id_t;
   typedef enum logic [1:0] {EMPTY, WRITE, RETIRE_ONLY} head_state_t;
   typedef struct packed {
      id_t                                   id;
      logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]  data;
      logic [NUM_WRITE_PORTS-1:0][4:0]       addr;
      logic [NUM_WRITE_PORTS-1:0]            pending;
   } rca_wb_entry_t;
endpackage

// File: rtl/rca_wb_entry_fifo.sv
// rca_wb_entry_fifo: in-order circular buffer of writeback entries with push/pop/count
module rca_wb_entry_fifo
   import rca_wb_serializer_pkg::*;
#(
   parameter type T = rca_wb_entry_t,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  T                           din,
   output T                           dout,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   T mem [DEPTH];
   logic [AW-1:0] wp, rp;
   assign dout = mem[rp];
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
   // storage needs no reset: count gates every read
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= din;
   end
endmodule

// File: rtl/rca_wb_serializer.sv
// rca_wb_serializer: buffers RCA writebacks and serializes them into single-port RF writes; optional same-cycle bypass via RCA_WB_BYPASS_EN
module rca_wb_serializer
   import rca_wb_serializer_pkg::id_t, rca_wb_serializer_pkg::head_state_t,
          rca_wb_serializer_pkg::EMPTY, rca_wb_serializer_pkg::WRITE,
          rca_wb_serializer_pkg::RETIRE_ONLY;
#(
   parameter int NUM_WRITE_PORTS = rca_wb_serializer_pkg::NUM_WRITE_PORTS,
   parameter int FIFO_DEPTH = 4,
   parameter int XLEN = rca_wb_serializer_pkg::XLEN
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 wb_done,
   input  id_t                                  wb_id,
   input  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] wb_rd,
   input  logic [NUM_WRITE_PORTS-1:0][4:0]      wb_rd_addr,
   input  logic [NUM_WRITE_PORTS-1:0]           wb_rd_en,
   output logic                                 wb_ready,
   output logic                                 rf_valid,
   output logic [4:0]                           rf_addr,
   output logic [XLEN-1:0]                      rf_data,
   output id_t                                  rf_id,
   output logic                                 rf_last,
   input  logic                                 rf_ack,
   output logic                                 retire_valid,
   output id_t                                  retire_id,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      occupancy
);
   localparam int N = NUM_WRITE_PORTS;
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam logic [N-1:0] ONE = 1;
   typedef struct packed {
      id_t                     id;
      logic [N-1:0][XLEN-1:0]  data;
      logic [N-1:0][4:0]       addr;
      logic [N-1:0]            pending;
   } entry_t;
   entry_t head, cur, push_e;
   head_state_t st;
   logic [N-1:0] wb_mask, sel, done;
   logic byp, push, pop, last, fire;
   assign wb_ready = occupancy < CW'(FIFO_DEPTH);
`ifdef RCA_WB_BYPASS_EN
   assign byp = (occupancy == '0) && wb_done;
`else
   assign byp = 1'b0;
`endif
   // x0 destinations never reach the register file
   always_comb begin
      wb_mask = wb_rd_en;
      for (int i = 0; i < N; i++) wb_mask[i] = wb_rd_en[i] && (wb_rd_addr[i] != 5'd0);
   end
   // head selection, lowest-pending-port write, retire and push/pop control
   always_comb begin
      cur = byp ? entry_t'{wb_id, wb_rd, wb_rd_addr, wb_mask}
                : entry_t'{head.id, head.data, head.addr, head.pending & ~done};
      st = (occupancy == '0 && !byp) ? EMPTY : (cur.pending != '0) ? WRITE : RETIRE_ONLY;
      rf_valid = st == WRITE;
      sel = rf_valid ? cur.pending & -cur.pending : '0;
      last = (cur.pending & (cur.pending - ONE)) == '0;
      rf_addr = '0;
      rf_data = '0;
      for (int i = 0; i < N; i++) begin
         if (sel[i]) begin
            rf_addr = cur.addr[i];
            rf_data = cur.data[i];
         end
      end
      rf_id = rf_valid ? cur.id : '0;
      rf_last = rf_valid && last;
      fire = rf_valid && rf_ack;
      retire_valid = (fire && last) || st == RETIRE_ONLY;
      retire_id = retire_valid ? cur.id : '0;
      pop = retire_valid && !byp;
      push = wb_done && wb_ready && !(byp && retire_valid);
      push_e = entry_t'{wb_id, wb_rd, wb_rd_addr, (byp && fire) ? wb_mask & ~sel : wb_mask};
   end
   // acked ports of the current head; cleared whenever the head advances
   always_ff @(posedge clk) begin
      if (rst || pop) done <= '0;
      else if (fire && !byp) done <= done | sel;
   end
`ifndef SYNTHESIS
   // a push into a full buffer is silently dropped by the hardware
   always_ff @(posedge clk) begin
      if (!rst) assert (!(wb_done && !wb_ready)) else $warning("wb_done while full: entry dropped");
   end
`endif
   rca_wb_entry_fifo #(.T(entry_t), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (push_e),
      .dout  (head),
      .count (occupancy)
   );
endmodule

// File: tb/tb_rca_wb_serializer.sv
// tb_rca_wb_serializer: directed vector table plus multi-cycle sequences for the writeback serializer
module tb_rca_wb_serializer;
   logic clk = 0;
   logic rst, wb_done, wb_ready, rf_valid, rf_last, rf_ack, retire_valid;
   logic [3:0] wb_id, rf_id, retire_id, wb_rd_en;
   logic [3:0][31:0] wb_rd;
   logic [3:0][4:0] wb_rd_addr;
   logic [4:0] rf_addr;
   logic [31:0] rf_data;
   logic [2:0] occupancy;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   rca_wb_serializer dut (
      .clk(clk), .rst(rst), .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd),
      .wb_rd_addr(wb_rd_addr), .wb_rd_en(wb_rd_en), .wb_ready(wb_ready),
      .rf_valid(rf_valid), .rf_addr(rf_addr), .rf_data(rf_data), .rf_id(rf_id),
      .rf_last(rf_last), .rf_ack(rf_ack), .retire_valid(retire_valid),
      .retire_id(retire_id), .occupancy(occupancy)
   );

   typedef struct {
      logic rst, done;
      logic [3:0] id, en;
      logic [3:0][4:0] addr;
      logic ack;
      logic ready, v;
      logic [4:0] a;
      logic [31:0] d;
      logic [3:0] rid;
      logic last, rv;
      logic [3:0] retid;
      logic [2:0] occ;
   } vec_t;

   typedef struct {
      logic [4:0] a;
      logic [31:0] d;
      logic [3:0] id;
      logic last;
   } wr_t;

   localparam logic [31:0] A0 = 32'hA000_0000, B1 = 32'hB111_1111, C2 = 32'hC222_2222, D3 = 32'hD333_3333;

   vec_t tv[22];
   wr_t wq[$];
   logic [3:0] rq[$];

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] en;
      logic [3:0][4:0] ad;
      logic [3:0][31:0] dt;
      logic hold, p_last;
      logic [4:0] p_a;
      logic [31:0] p_d;
      logic [3:0] p_id;
      int np, cyc;
      wr_t w;
      //             rst done id  en       addr                                 ack  rdy v a      d   rid last rv retid occ
      tv[0]  = '{1, 0, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   0,   1, 0, 5'd0,  0,  0, 0, 0, 0, 0};
      tv[1]  = '{0, 0, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   1,   1, 0, 5'd0,  0,  0, 0, 0, 0, 0};
      tv[2]  = '{0, 1, 3, 4'b1011, {5'd8, 5'd7, 5'd6, 5'd5},   1,   1, 0, 5'd0,  0,  0, 0, 0, 0, 0};
      tv[3]  = '{0, 0, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   1,   1, 1, 5'd5,  A0, 3, 0, 0, 0, 1};
      tv[4]  = '{0, 0, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   1,   1, 1, 5'd6,  B1, 3, 0, 0, 0, 1};
      tv[5]  = '{0, 0, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   1,   1, 1, 5'd8,  D3, 3, 1, 1, 3, 1};
      tv[6]  = '{0, 0, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   1,   1, 0, 5'd0,  0,  0, 0, 0, 0, 0};
      tv[7]  = '{0, 1, 1, 4'b0101, {5'd0, 5'd9, 5'd0, 5'd0},   1,   1, 0, 5'd0,  0,  0, 0, 0, 0, 0};
      tv[8]  = '{0, 0, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   1,   1, 1, 5'd9,  C2, 1, 1, 1, 1, 1};
      tv[9]  = '{0, 0, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   1,   1, 0, 5'd0,  0,  0, 0, 0, 0, 0};
      tv[10] = '{0, 1, 7, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   1,   1, 0, 5'd0,  0,  0, 0, 0, 0, 0};
      tv[11] = '{0, 0, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   1,   1, 0, 5'd0,  0,  0, 0, 1, 7, 1};
      tv[12] = '{0, 0, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   1,   1, 0, 5'd0,  0,  0, 0, 0, 0, 0};
      tv[13] = '{0, 1, 2, 4'b0011, {5'd0, 5'd0, 5'd11, 5'd10}, 1,   1, 0, 5'd0,  0,  0, 0, 0, 0, 0};
      tv[14] = '{0, 1, 4, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd12},  1,   1, 1, 5'd10, A0, 2, 0, 0, 0, 1};
      tv[15] = '{0, 0, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   1,   1, 1, 5'd11, B1, 2, 1, 1, 2, 2};
      tv[16] = '{0, 0, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   1,   1, 1, 5'd12, A0, 4, 1, 1, 4, 1};
      tv[17] = '{0, 0, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   1,   1, 0, 5'd0,  0,  0, 0, 0, 0, 0};
      tv[18] = '{0, 1, 9, 4'b1000, {5'd13, 5'd0, 5'd0, 5'd0},  0,   1, 0, 5'd0,  0,  0, 0, 0, 0, 0};
      tv[19] = '{0, 0, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   0,   1, 1, 5'd13, D3, 9, 1, 0, 0, 1};
      tv[20] = '{0, 0, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   1,   1, 1, 5'd13, D3, 9, 1, 1, 9, 1};
      tv[21] = '{0, 0, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   1,   1, 0, 5'd0,  0,  0, 0, 0, 0, 0};

      rst = 1; wb_done = 0; wb_id = 0; wb_rd_en = 0; wb_rd_addr = '0; rf_ack = 0;
      wb_rd = {D3, C2, B1, A0};
      step();
      for (int i = 0; i < 22; i++) begin
         rst = tv[i].rst; wb_done = tv[i].done; wb_id = tv[i].id; wb_rd_en = tv[i].en;
         wb_rd_addr = tv[i].addr; rf_ack = tv[i].ack;
         #4;
         chk($sformatf("v%0d wb_ready", i), wb_ready, tv[i].ready);
         chk($sformatf("v%0d rf_valid", i), rf_valid, tv[i].v);
         chk($sformatf("v%0d rf_addr", i), rf_addr, tv[i].a);
         chk($sformatf("v%0d rf_data", i), rf_data, tv[i].d);
         chk($sformatf("v%0d rf_id", i), rf_id, tv[i].rid);
         chk($sformatf("v%0d rf_last", i), rf_last, tv[i].last);
         chk($sformatf("v%0d retire_valid", i), retire_valid, tv[i].rv);
         chk($sformatf("v%0d retire_id", i), retire_id, tv[i].retid);
         chk($sformatf("v%0d occupancy", i), occupancy, tv[i].occ);
         step();
      end

      // fill to full with no acks, fifth push must be dropped
      for (int i = 0; i < 5; i++) begin
         wb_done = 1; wb_id = 4'(8 + i); wb_rd_en = 4'b0011; wb_rd_addr = {5'd0, 5'd0, 5'd2, 5'd1}; rf_ack = 0;
         #4;
         chk($sformatf("full%0d wb_ready", i), wb_ready, i < 4);
         chk($sformatf("full%0d occupancy", i), occupancy, (i < 4) ? i : 4);
         if (i > 0) begin
            chk($sformatf("full%0d hold rf_valid", i), rf_valid, 1);
            chk($sformatf("full%0d hold rf_addr", i), rf_addr, 1);
            chk($sformatf("full%0d hold rf_id", i), rf_id, 8);
            chk($sformatf("full%0d hold rf_last", i), rf_last, 0);
         end
         step();
      end
      wb_done = 0; rf_ack = 1;
      for (int w2 = 0; w2 < 8; w2++) begin
         #4;
         chk($sformatf("drain%0d rf_valid", w2), rf_valid, 1);
         chk($sformatf("drain%0d rf_id", w2), rf_id, 8 + w2 / 2);
         chk($sformatf("drain%0d rf_addr", w2), rf_addr, 1 + w2 % 2);
         chk($sformatf("drain%0d rf_last", w2), rf_last, w2 % 2);
         chk($sformatf("drain%0d retire_valid", w2), retire_valid, w2 % 2);
         chk($sformatf("drain%0d retire_id", w2), retire_id, (w2 % 2) ? 8 + w2 / 2 : 0);
         chk($sformatf("drain%0d wb_ready", w2), wb_ready, w2 >= 2);
         chk($sformatf("drain%0d occupancy", w2), occupancy, 4 - w2 / 2);
         step();
      end
      #4;
      chk("drain_end rf_valid", rf_valid, 0);
      chk("drain_end occupancy", occupancy, 0);
      chk("drain_end retire_valid", retire_valid, 0);
      step();

      // reset in the middle of a three-port drain
      wb_done = 1; wb_id = 5; wb_rd_en = 4'b0111; wb_rd_addr = {5'd0, 5'd5, 5'd4, 5'd3}; rf_ack = 1;
      step();
      wb_done = 0;
      #4;
      chk("rst_mid first write addr", rf_addr, 3);
      chk("rst_mid first write valid", rf_valid, 1);
      step();
      rst = 1; rf_ack = 0;
      #4;
      chk("rst_mid rst cycle retire", retire_valid, 0);
      step();
      rst = 0;
      #4;
      chk("rst_mid after rf_valid", rf_valid, 0);
      chk("rst_mid after occupancy", occupancy, 0);
      chk("rst_mid after retire", retire_valid, 0);
      chk("rst_mid after wb_ready", wb_ready, 1);
      chk("rst_mid after rf_addr", rf_addr, 0);
      step();
      wb_done = 1; wb_id = 6; wb_rd_en = 4'b0001; wb_rd_addr = {5'd0, 5'd0, 5'd0, 5'd7}; rf_ack = 1;
      step();
      wb_done = 0;
      #4;
      chk("rst_new rf_addr", rf_addr, 7);
      chk("rst_new rf_id", rf_id, 6);
      chk("rst_new retire_valid", retire_valid, 1);
      chk("rst_new retire_id", retire_id, 6);
      step();

      // random ack stalls against a queue model
      np = 0; cyc = 0; hold = 0; p_a = 0; p_d = 0; p_id = 0; p_last = 0;
      while ((np < 8 || wq.size() != 0 || rq.size() != 0) && cyc < 400) begin
         wb_done = 0;
         if (np < 8 && wb_ready) begin
            en = (np == 3) ? 4'b0000 : 4'($urandom_range(0, 15));
            for (int p = 0; p < 4; p++) begin
               ad[p] = 5'($urandom_range(0, 31));
               dt[p] = $urandom;
            end
            if (np == 5) ad[1] = 5'd0;
            wb_done = 1; wb_id = 4'(np + 1); wb_rd_en = en; wb_rd_addr = ad; wb_rd = dt;
            for (int p = 0; p < 4; p++) begin
               if (en[p] && ad[p] != 0) begin
                  w.a = ad[p]; w.d = dt[p]; w.id = 4'(np + 1); w.last = 0;
                  wq.push_back(w);
               end
            end
            if (wq.size() != 0 && wq[$].id == 4'(np + 1)) wq[$].last = 1;
            rq.push_back(4'(np + 1));
            np++;
         end
         rf_ack = 1'($urandom_range(0, 1));
         #4;
         if (hold) begin
            chk("stall rf_valid", rf_valid, 1);
            chk("stall rf_addr", rf_addr, p_a);
            chk("stall rf_data", rf_data, p_d);
            chk("stall rf_id", rf_id, p_id);
            chk("stall rf_last", rf_last, p_last);
         end
         if (rf_valid) begin
            if (wq.size() == 0) chk("rand unexpected write", rf_valid, 0);
            else begin
               chk("rand rf_addr", rf_addr, wq[0].a);
               chk("rand rf_data", rf_data, wq[0].d);
               chk("rand rf_id", rf_id, wq[0].id);
               chk("rand rf_last", rf_last, wq[0].last);
               if (rf_ack) void'(wq.pop_front());
            end
         end
         if (retire_valid) begin
            if (rq.size() == 0) chk("rand unexpected retire", retire_valid, 0);
            else begin
               chk("rand retire_id", retire_id, rq[0]);
               chk("rand retire after all writes", wq.size() != 0 && wq[0].id == rq[0], 0);
               void'(rq.pop_front());
            end
         end
         hold = rf_valid && !rf_ack;
         p_a = rf_addr; p_d = rf_data; p_id = rf_id; p_last = rf_last;
         cyc++;
         step();
      end
      chk("rand all pushed", np, 8);
      chk("rand writes drained", wq.size(), 0);
      chk("rand retires drained", rq.size(), 0);
      wb_done = 0; rf_ack = 0;
      #4;
      chk("rand end occupancy", occupancy, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
